// File: rtl/fetch_ctrl.sv
// Instruction-fetch controller: sequences IMEM requests, resolves PC redirects and pipeline stalls.
// Optional stall-cycle counter port enabled by defining FETCH_STALL_CNT_EN.
module fetch_ctrl #(
    parameter int PC_INC = 4
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        start_i,
    input  logic [31:0] pc_i,
    input  logic        load_use_i,
    input  logic        branch_i,
    input  logic [31:0] branch_addr_i,
    input  logic        jump_i,
    input  logic [31:0] jump_addr_i,
    input  logic        imem_ack_i,
    output logic        imem_req_o,
    output logic [31:0] pc_next_o,
    output logic        pc_stall_o,
    output logic        ifid_stall_o,
    output logic        ifid_flush_o,
    output logic        idex_bubble_o,
    output logic [1:0]  state_o
`ifdef FETCH_STALL_CNT_EN
    ,
    output logic [31:0] stall_cnt_o
`endif
);

    typedef enum logic [1:0] {
        IDLE     = 2'b00,
        FETCH    = 2'b01,
        WAIT_MEM = 2'b10
    } state_t;

    state_t      r_state;
    state_t      w_state_next;
    logic        r_pend_v;
    logic [31:0] r_pend_addr;
    logic        w_pend_v_next;
    logic [31:0] w_pend_addr_next;
    logic [31:0] w_pc;
    logic [31:0] w_pc_seq;

    assign w_pc_seq = pc_i + 32'(PC_INC);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state     <= IDLE;
            r_pend_v    <= 1'b0;
            r_pend_addr <= 32'h0;
        end else begin
            r_state     <= w_state_next;
            r_pend_v    <= w_pend_v_next;
            r_pend_addr <= w_pend_addr_next;
        end
    end

    always_comb begin
        w_state_next     = r_state;
        w_pend_v_next    = r_pend_v;
        w_pend_addr_next = r_pend_addr;
        w_pc             = pc_i;
        imem_req_o       = 1'b0;
        pc_stall_o       = 1'b0;
        ifid_stall_o     = 1'b0;
        ifid_flush_o     = 1'b0;
        idex_bubble_o    = 1'b0;

        case (r_state)
            IDLE: begin
                pc_stall_o = 1'b1;
                if (start_i) w_state_next = FETCH;
            end
            FETCH, WAIT_MEM: begin
                imem_req_o    = 1'b1;
                idex_bubble_o = load_use_i;
                if (imem_ack_i) begin
                    w_state_next  = FETCH;
                    w_pend_v_next = 1'b0;
                    // Live redirects outrank a redirect captured while waiting on memory.
                    if (load_use_i) begin
                        pc_stall_o   = 1'b1;
                        ifid_stall_o = 1'b1;
                    end else if (jump_i) begin
                        w_pc         = jump_addr_i;
                        ifid_flush_o = 1'b1;
                    end else if (branch_i) begin
                        w_pc         = branch_addr_i;
                        ifid_flush_o = 1'b1;
                    end else if (r_state == WAIT_MEM && r_pend_v) begin
                        w_pc         = r_pend_addr;
                        ifid_flush_o = 1'b1;
                    end else begin
                        w_pc = w_pc_seq;
                    end
                end else begin
                    w_state_next = WAIT_MEM;
                    pc_stall_o   = 1'b1;
                    ifid_stall_o = 1'b1;
                    if (r_state == WAIT_MEM && !load_use_i && (jump_i || branch_i)) begin
                        w_pend_v_next    = 1'b1;
                        w_pend_addr_next = jump_i ? jump_addr_i : branch_addr_i;
                    end
                end
            end
            default: w_state_next = IDLE;
        endcase

        // Dropping run enable abandons any outstanding fetch immediately.
        if (!start_i) begin
            w_state_next  = IDLE;
            w_pend_v_next = 1'b0;
        end
    end

    assign pc_next_o = w_pc & 32'hFFFF_FFFC;
    assign state_o   = r_state;

`ifdef FETCH_STALL_CNT_EN
    logic [31:0] r_stall_cnt;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_stall_cnt <= 32'h0;
        end else if (pc_stall_o && r_state != IDLE && r_stall_cnt != 32'hFFFF_FFFF) begin
            r_stall_cnt <= r_stall_cnt + 32'h1;
        end
    end

    assign stall_cnt_o = r_stall_cnt;
`endif

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed-vector bench for fetch_ctrl; one task per scenario, inline comparisons.
module tb_fetch_ctrl;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        start_i;
    logic [31:0] pc_i;
    logic        load_use_i;
    logic        branch_i;
    logic [31:0] branch_addr_i;
    logic        jump_i;
    logic [31:0] jump_addr_i;
    logic        imem_ack_i;
    logic        imem_req_o;
    logic [31:0] pc_next_o;
    logic        pc_stall_o;
    logic        ifid_stall_o;
    logic        ifid_flush_o;
    logic        idex_bubble_o;
    logic [1:0]  state_o;
`ifdef FETCH_STALL_CNT_EN
    logic [31:0] stall_cnt_o;
`endif

    int pass_cnt  = 0;
    int total_cnt = 0;

    fetch_ctrl #(.PC_INC(4)) dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .start_i       (start_i),
        .pc_i          (pc_i),
        .load_use_i    (load_use_i),
        .branch_i      (branch_i),
        .branch_addr_i (branch_addr_i),
        .jump_i        (jump_i),
        .jump_addr_i   (jump_addr_i),
        .imem_ack_i    (imem_ack_i),
        .imem_req_o    (imem_req_o),
        .pc_next_o     (pc_next_o),
        .pc_stall_o    (pc_stall_o),
        .ifid_stall_o  (ifid_stall_o),
        .ifid_flush_o  (ifid_flush_o),
        .idex_bubble_o (idex_bubble_o),
        .state_o       (state_o)
`ifdef FETCH_STALL_CNT_EN
        ,
        .stall_cnt_o   (stall_cnt_o)
`endif
    );

    always #5 clk_i = ~clk_i;

    // Advance one clock; inputs change 1 time unit after the edge.
    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic clear_events();
        load_use_i = 1'b0;
        branch_i   = 1'b0;
        jump_i     = 1'b0;
    endtask

    // Reset, then bring the FSM into FETCH with ack high.
    task automatic reset_to_fetch(input logic [31:0] pc);
        rst_i = 1'b1; start_i = 1'b1; imem_ack_i = 1'b1; pc_i = pc;
        clear_events();
        tick();
        rst_i = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        rst_i = 1'b1; start_i = 1'b1; pc_i = 32'h100; imem_ack_i = 1'b1;
        load_use_i = 1'b0; branch_i = 1'b1; branch_addr_i = 32'h40;
        jump_i = 1'b1; jump_addr_i = 32'h80;
        tick(); tick();
        #1;
        total_cnt++; if (state_o !== 2'b00) $display("FAIL reset_state: got %b want 00", state_o); else pass_cnt++;
        total_cnt++; if ({imem_req_o, pc_stall_o, ifid_stall_o, ifid_flush_o, idex_bubble_o} !== 5'b01000)
            $display("FAIL reset_ctrl: got %b want 01000", {imem_req_o, pc_stall_o, ifid_stall_o, ifid_flush_o, idex_bubble_o});
        else pass_cnt++;
        total_cnt++; if (pc_next_o !== 32'h100) $display("FAIL reset_pc: got %h want 00000100", pc_next_o); else pass_cnt++;
        clear_events();
    endtask

    task automatic test_sequential();
        rst_i = 1'b0; start_i = 1'b1; imem_ack_i = 1'b1; pc_i = 32'h100;
        #1;
        total_cnt++; if (state_o !== 2'b00) $display("FAIL seq_idle: got %b want 00", state_o); else pass_cnt++;
        tick();
        total_cnt++; if (state_o !== 2'b01) $display("FAIL seq_state: got %b want 01", state_o); else pass_cnt++;
        total_cnt++; if (pc_next_o !== 32'h104) $display("FAIL seq_pc: got %h want 00000104", pc_next_o); else pass_cnt++;
        total_cnt++; if ({imem_req_o, pc_stall_o, ifid_stall_o, ifid_flush_o} !== 4'b1000)
            $display("FAIL seq_ctrl: got %b want 1000", {imem_req_o, pc_stall_o, ifid_stall_o, ifid_flush_o});
        else pass_cnt++;
    endtask

    task automatic test_wait_mem();
        pc_i = 32'h104; imem_ack_i = 1'b0;
        for (int c = 0; c < 3; c++) begin
            #1;
            total_cnt++; if ({pc_stall_o, ifid_stall_o, imem_req_o} !== 3'b111 || pc_next_o !== 32'h104)
                $display("FAIL wait_stall%0d: got stall=%b pc=%h want 111 pc=00000104", c, {pc_stall_o, ifid_stall_o, imem_req_o}, pc_next_o);
            else pass_cnt++;
            tick();
        end
        total_cnt++; if (state_o !== 2'b10) $display("FAIL wait_state: got %b want 10", state_o); else pass_cnt++;
        imem_ack_i = 1'b1;
        #1;
        total_cnt++; if (pc_next_o !== 32'h108 || pc_stall_o !== 1'b0 || ifid_flush_o !== 1'b0)
            $display("FAIL wait_ack: got pc=%h stall=%b flush=%b want 00000108 0 0", pc_next_o, pc_stall_o, ifid_flush_o);
        else pass_cnt++;
        tick();
        total_cnt++; if (state_o !== 2'b01) $display("FAIL wait_back: got %b want 01", state_o); else pass_cnt++;
    endtask

    task automatic test_pending_branch();
        pc_i = 32'h108; imem_ack_i = 1'b0;
        tick();
        branch_i = 1'b1; branch_addr_i = 32'h200;
        #1;
        total_cnt++; if (pc_next_o !== 32'h108 || ifid_flush_o !== 1'b0)
            $display("FAIL pend_capture: got pc=%h flush=%b want 00000108 0", pc_next_o, ifid_flush_o);
        else pass_cnt++;
        tick();
        branch_i = 1'b0;
        tick();
        imem_ack_i = 1'b1;
        #1;
        total_cnt++; if (pc_next_o !== 32'h200 || ifid_flush_o !== 1'b1)
            $display("FAIL pend_apply: got pc=%h flush=%b want 00000200 1", pc_next_o, ifid_flush_o);
        else pass_cnt++;
        tick();
        pc_i = 32'h200;
        #1;
        total_cnt++; if (pc_next_o !== 32'h204 || ifid_flush_o !== 1'b0)
            $display("FAIL pend_cleared: got pc=%h flush=%b want 00000204 0", pc_next_o, ifid_flush_o);
        else pass_cnt++;
    endtask

    task automatic test_load_use();
        pc_i = 32'h204; imem_ack_i = 1'b1;
        load_use_i = 1'b1; jump_i = 1'b1; jump_addr_i = 32'h300;
        #1;
        total_cnt++; if ({pc_stall_o, ifid_stall_o, idex_bubble_o, ifid_flush_o} !== 4'b1110 || pc_next_o !== 32'h204)
            $display("FAIL load_use: got ctl=%b pc=%h want 1110 00000204", {pc_stall_o, ifid_stall_o, idex_bubble_o, ifid_flush_o}, pc_next_o);
        else pass_cnt++;
        load_use_i = 1'b0; branch_i = 1'b1; branch_addr_i = 32'h500;
        #1;
        total_cnt++; if (pc_next_o !== 32'h300 || ifid_flush_o !== 1'b1)
            $display("FAIL jump_over_branch: got pc=%h flush=%b want 00000300 1", pc_next_o, ifid_flush_o);
        else pass_cnt++;
        jump_i = 1'b0; branch_addr_i = 32'h503;
        #1;
        total_cnt++; if (pc_next_o !== 32'h500) $display("FAIL branch_align: got %h want 00000500", pc_next_o); else pass_cnt++;
        clear_events();
    endtask

    task automatic test_pending_override();
        reset_to_fetch(32'h600);
        imem_ack_i = 1'b0;
        tick();
        jump_i = 1'b1; jump_addr_i = 32'h400; branch_i = 1'b1; branch_addr_i = 32'h440;
        tick();
        clear_events(); imem_ack_i = 1'b1; branch_i = 1'b1; branch_addr_i = 32'h500;
        #1;
        total_cnt++; if (pc_next_o !== 32'h500 || ifid_flush_o !== 1'b1)
            $display("FAIL live_over_pend: got pc=%h flush=%b want 00000500 1", pc_next_o, ifid_flush_o);
        else pass_cnt++;
        clear_events();
        // Capture again, without a live event: the jump target must have won the capture.
        reset_to_fetch(32'h600);
        imem_ack_i = 1'b0;
        tick();
        jump_i = 1'b1; jump_addr_i = 32'h400; branch_i = 1'b1; branch_addr_i = 32'h440;
        tick();
        clear_events(); imem_ack_i = 1'b1;
        #1;
        total_cnt++; if (pc_next_o !== 32'h400) $display("FAIL pend_jump_wins: got %h want 00000400", pc_next_o); else pass_cnt++;
        tick();
    endtask

    task automatic test_wrap();
        pc_i = 32'hFFFF_FFFC; imem_ack_i = 1'b1; clear_events();
        #1;
        total_cnt++; if (pc_next_o !== 32'h0000_0000) $display("FAIL pc_wrap: got %h want 00000000", pc_next_o); else pass_cnt++;
    endtask

    task automatic test_reset_in_wait();
        reset_to_fetch(32'h700);
        imem_ack_i = 1'b0;
        tick();
        branch_i = 1'b1; branch_addr_i = 32'h900;
        tick();
        clear_events();
        rst_i = 1'b1;
        tick();
        total_cnt++; if (state_o !== 2'b00 || imem_req_o !== 1'b0)
            $display("FAIL rst_wait: got state=%b req=%b want 00 0", state_o, imem_req_o);
        else pass_cnt++;
        rst_i = 1'b0;
        tick();
        tick();
        total_cnt++; if (state_o !== 2'b10) $display("FAIL rst_rewait: got %b want 10", state_o); else pass_cnt++;
        imem_ack_i = 1'b1;
        #1;
        total_cnt++; if (pc_next_o !== 32'h704 || ifid_flush_o !== 1'b0)
            $display("FAIL rst_pend_gone: got pc=%h flush=%b want 00000704 0", pc_next_o, ifid_flush_o);
        else pass_cnt++;
    endtask

    task automatic test_start_low();
        reset_to_fetch(32'h800);
        imem_ack_i = 1'b0;
        tick();
        start_i = 1'b0;
        tick();
        total_cnt++; if (state_o !== 2'b00 || imem_req_o !== 1'b0 || pc_stall_o !== 1'b1)
            $display("FAIL start_low: got state=%b req=%b stall=%b want 00 0 1", state_o, imem_req_o, pc_stall_o);
        else pass_cnt++;
        start_i = 1'b1;
    endtask

`ifdef FETCH_STALL_CNT_EN
    task automatic test_stall_cnt();
        rst_i = 1'b1; start_i = 1'b1; imem_ack_i = 1'b0; clear_events();
        tick();
        rst_i = 1'b0;
        tick();
        for (int c = 0; c < 5; c++) tick();
        total_cnt++; if (stall_cnt_o !== 32'd5) $display("FAIL stall_cnt: got %0d want 5", stall_cnt_o); else pass_cnt++;
    endtask
`endif

    initial begin
        rst_i = 1'b1; start_i = 1'b0; pc_i = 32'h0; imem_ack_i = 1'b0;
        branch_addr_i = 32'h0; jump_addr_i = 32'h0;
        clear_events();
        test_reset();
        test_sequential();
        test_wait_mem();
        test_pending_branch();
        test_load_use();
        test_wrap();
        test_pending_override();
        test_reset_in_wait();
        test_start_low();
`ifdef FETCH_STALL_CNT_EN
        test_stall_cnt();
`endif
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/fetch_ctrl.md
FETCH_CTRL -- requirements
Module: fetch_ctrl

Interface
REQ-001 Parameter PC_INC, default 4: sequential PC increment in bytes.
REQ-002 The block SHALL have one clock; reset is synchronous and active-high, on ports clk_i and rst_i.
REQ-003 clk_i  input  1  rising-edge clock.
REQ-004 rst_i  input  1  synchronous, active-high reset.
REQ-005 start_i  input  1  run enable; low forces IDLE.
REQ-006 pc_i  input  32  current PC register value.
REQ-007 load_use_i  input  1  load-use hazard detected in ID.
REQ-008 branch_i  input  1  branch resolved taken in ID.
REQ-009 branch_addr_i  input  32  branch target.
REQ-010 jump_i  input  1  jump in ID.
REQ-011 jump_addr_i  input  32  jump target.
REQ-012 imem_ack_i  input  1  instruction memory returns the fetch this cycle.
REQ-013 imem_req_o  output  1  fetch request.
REQ-014 pc_next_o  output  32  next PC value, drives the PC register input.
REQ-015 pc_stall_o  output  1  PC hold, drives the PC register hold input.
REQ-016 ifid_stall_o  output  1  hold the IF/ID register.
REQ-017 ifid_flush_o  output  1  zero the IF/ID register.
REQ-018 idex_bubble_o  output  1  insert a NOP into ID/EX.
REQ-019 state_o  output  2  current state: IDLE=00, FETCH=01, WAIT_MEM=10.

Function
REQ-020 State SHALL be registered; all other outputs SHALL be combinational from state, pending registers and inputs (zero-cycle latency).
REQ-021 IDLE: imem_req_o=0, pc_stall_o=1, all other control outputs 0; start_i=1 -> FETCH next cycle.
REQ-022 FETCH: imem_req_o=1; imem_ack_i=0 -> WAIT_MEM, pc_stall_o=1, ifid_stall_o=1; imem_ack_i=1 -> remain FETCH and update PC per REQ-023.
REQ-023 Update priority when acked: load_use_i (pc_stall_o=1, ifid_stall_o=1, idex_bubble_o=1, pc_next_o=pc_i, branch/jump ignored) > jump_i (pc_next_o=jump_addr_i, ifid_flush_o=1) > branch_i (pc_next_o=branch_addr_i, ifid_flush_o=1) > sequential (pc_next_o=pc_i+PC_INC).
REQ-024 WAIT_MEM: imem_req_o=1, pc_stall_o=1, ifid_stall_o=1, pc_next_o=pc_i; imem_ack_i=1 -> FETCH, PC updates that cycle.
REQ-025 A jump_i or branch_i seen in WAIT_MEM without load_use_i SHALL be captured into a pending-valid flag and a 32-bit pending address; a later capture overwrites it; jump beats branch in the same cycle.
REQ-026 When ack arrives in WAIT_MEM with pending valid, pc_next_o=pending address, ifid_flush_o=1, pending cleared next cycle; live jump/branch in that cycle overrides pending.
REQ-027 idex_bubble_o SHALL assert in FETCH or WAIT_MEM whenever load_use_i=1.
REQ-028 pc_i+PC_INC SHALL wrap modulo 2^32 (0xFFFFFFFC+4 -> 0x00000000).
REQ-029 pc_next_o[1:0] SHALL always be 00.
REQ-030 start_i=0 in any state -> IDLE next cycle, pending cleared, request dropped without waiting for ack.

Reset
REQ-031 rst_i=1 at a clock edge SHALL force IDLE and clear pending-valid, pending address and the stall counter, overriding start_i and all events.
REQ-032 While in reset/IDLE: imem_req_o=0, pc_stall_o=1, ifid_stall_o=0, ifid_flush_o=0, idex_bubble_o=0, state_o=00, pc_next_o=pc_i.
REQ-033 Reset mid-WAIT_MEM SHALL discard the outstanding fetch and pending redirect.

Configuration
REQ-034 Macro FETCH_STALL_CNT_EN defined: add output stall_cnt_o (32), counting cycles with pc_stall_o=1 outside IDLE, saturating at 0xFFFFFFFF, cleared by reset.
REQ-035 Macro undefined: port and counter absent; all other behaviour identical.

Verification
REQ-036 Reset, then start_i=1, pc_i=0x100, ack every cycle -> pc_next_o 0x104, state 00->01, no stall.
REQ-037 FETCH, ack=0 for 3 cycles -> WAIT_MEM, pc_stall_o=1 for 3 cycles; 4th-cycle ack -> pc_next_o=pc_i+4.
REQ-038 WAIT_MEM, branch_i=1 addr 0x200 one cycle, ack 2 cycles later -> pc_next_o=0x200, ifid_flush_o=1 on ack cycle.
REQ-039 load_use_i=1 with jump_i=1 addr 0x300, ack=1 -> pc_stall_o=1, idex_bubble_o=1, ifid_flush_o=0, pc_next_o=pc_i.
REQ-040 pc_i=0xFFFFFFFC sequential -> pc_next_o=0x00000000; rst_i=1 in WAIT_MEM -> state_o=00, imem_req_o=0 next cycle.
REQ-041 With FETCH_STALL_CNT_EN, 5 stall cycles after reset -> stall_cnt_o=5.
